// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection, EPC capture and
// the BOOT/RUN/EXC/HALT exception state machine. State advances on the falling edge.
module pc_fetch_unit #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] EXC_VECTOR = 8'hF0,
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            SYS_load,
  input  logic [PC_W-1:0] SYS_pc_val,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [7:0]      branch_offset,
  input  logic            jump,
  input  logic [5:0]      jump_target,
  input  logic            exception,
  input  logic            exc_ack,
  output logic [PC_W-1:0] fetch_pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] epc,
  output logic            exc_pending,
  output logic            fetch_valid,
  output logic [1:0]      fsm_state
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, EXC = 2'd2, HALT = 2'd3} state_t;

  // Word alignment is enforced even if a parameter is given unaligned.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] EXC_PC     = EXC_VECTOR & ALIGN_MASK;
  localparam logic [PC_W-1:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx, epc_nx;
  logic            pend_nx;
  logic [PC_W-1:0] off_sx, br_tgt, jmp_tgt;

  assign pc_plus4    = fetch_pc + PC_W'(4);
  assign off_sx      = PC_W'($signed(branch_offset));
  assign br_tgt      = pc_plus4 + {off_sx[PC_W-3:0], 2'b00};
  assign jmp_tgt     = {pc_plus4[PC_W-1:6], jump_target[5:2], 2'b00};
  assign fetch_valid = (state == RUN) && !stall;
  assign fsm_state   = state;

  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    epc_nx   = epc;
    pend_nx  = exc_pending;
    if (SYS_load) begin
      pc_nx    = SYS_pc_val & ALIGN_MASK;
      pend_nx  = 1'b0;
      state_nx = RUN;
    end else begin
      case (state)
        BOOT: state_nx = RUN;
        EXC:  state_nx = RUN;
        HALT: state_nx = HALT;
        RUN: begin
          if (exception) begin
            // A fault while the previous one is still unacknowledged freezes the core.
            if (!exc_pending) begin
              epc_nx   = fetch_pc;
              pc_nx    = EXC_PC;
              pend_nx  = 1'b1;
              state_nx = EXC;
            end else begin
              state_nx = HALT;
            end
          end else begin
            if (exc_ack) pend_nx = 1'b0;
            if (!stall) begin
              if (jump)              pc_nx = jmp_tgt;
              else if (branch_taken) pc_nx = br_tgt;
              else                   pc_nx = pc_plus4;
            end
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state       <= BOOT;
      fetch_pc    <= BOOT_PC;
      epc         <= '0;
      exc_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= pc_nx;
      epc         <= epc_nx;
      exc_pending <= pend_nx;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through the fetch/exception scenarios,
// then randomized traffic against an arithmetic reference model.
module tb_pc_fetch_unit;
  logic       SYS_clk, SYS_reset, SYS_load, stall, branch_taken, jump, exception, exc_ack;
  logic [7:0] SYS_pc_val, branch_offset;
  logic [5:0] jump_target;
  logic [7:0] fetch_pc, pc_plus4, epc;
  logic       exc_pending, fetch_valid;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;
  // Reference model: PC as an integer mod 256, state numbered as fsm_state.
  int m_pc, m_epc, m_pend, m_st;

  pc_fetch_unit dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .exception(exception), .exc_ack(exc_ack),
    .fetch_pc(fetch_pc), .pc_plus4(pc_plus4), .epc(epc), .exc_pending(exc_pending),
    .fetch_valid(fetch_valid), .fsm_state(fsm_state)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_epc = 0; m_pend = 0; m_st = 0;
  endtask

  task automatic chk_all(input logic stl);
    chk("fetch_pc", fetch_pc, m_pc);
    chk("epc", epc, m_epc);
    chk("exc_pending", exc_pending, m_pend);
    chk("fsm_state", fsm_state, m_st);
    chk("fetch_valid", fetch_valid, (m_st == 1) && !stl);
    chk("pc_plus4", pc_plus4, (m_pc + 4) % 256);
  endtask

  task automatic tick(input logic ld, input logic [7:0] pcv, input logic stl, input logic br,
                      input logic [7:0] off, input logic jp, input logic [5:0] jt,
                      input logic ex, input logic ack);
    int so;
    SYS_load = ld; SYS_pc_val = pcv; stall = stl; branch_taken = br; branch_offset = off;
    jump = jp; jump_target = jt; exception = ex; exc_ack = ack;
    #1;
    chk("fetch_valid_pre", fetch_valid, (m_st == 1) && !stl);
    @(negedge SYS_clk);
    so = int'($signed(off));
    if (ld) begin
      m_pc = pcv & 'hFC; m_pend = 0; m_st = 1;
    end else if (m_st == 0 || m_st == 2) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (ex) begin
        if (m_pend == 0) begin m_epc = m_pc; m_pc = 'hF0; m_pend = 1; m_st = 2; end
        else m_st = 3;
      end else begin
        if (ack) m_pend = 0;
        if (!stl) begin
          if (jp)      m_pc = ((m_pc + 4) & 'hC0) | (jt & 'h3C);
          else if (br) m_pc = (m_pc + 4 + 4 * so + 1024) % 256;
          else         m_pc = (m_pc + 4) % 256;
        end
      end
    end
    #1;
    chk_all(stl);
  endtask

  task automatic idle();
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 0, 0);
  endtask

  initial begin
    SYS_reset = 1'b1; SYS_load = 0; SYS_pc_val = 0; stall = 0; branch_taken = 0;
    branch_offset = 0; jump = 0; jump_target = 0; exception = 0; exc_ack = 0;
    model_reset();
    #2;
    chk_all(0);
    @(negedge SYS_clk); @(negedge SYS_clk); #2;
    chk_all(0);
    SYS_reset = 1'b0;

    // Boot bubble then sequential fetch
    idle();
    chk("tp_boot_pc", fetch_pc, 8'h00);
    repeat (4) idle();
    chk("tp_seq_pc", fetch_pc, 8'h10);

    tick(0, 8'h00, 0, 1, 8'hFE, 0, 6'h00, 0, 0);
    chk("tp_branch_back", fetch_pc, 8'h0C);
    tick(0, 8'h00, 0, 1, 8'h05, 1, 6'h2A, 0, 0);
    chk("tp_jump_wins", fetch_pc, 8'h28);
    tick(0, 8'h00, 0, 0, 8'h00, 1, 6'h20, 0, 0);
    chk("tp_jump_to_20", fetch_pc, 8'h20);

    // Exception capture, bubble, then double fault into HALT
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 1, 0);
    chk("tp_exc_epc", epc, 8'h20);
    chk("tp_exc_pc", fetch_pc, 8'hF0);
    idle();
    idle();
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 1, 0);
    chk("tp_halt_state", fsm_state, 2'd3);
    tick(0, 8'h00, 0, 1, 8'h10, 1, 6'h3C, 1, 1);
    idle();
    chk("tp_halt_pc", fetch_pc, 8'hF4);
    chk("tp_halt_epc", epc, 8'h20);

    tick(1, 8'h47, 0, 0, 8'h00, 0, 6'h00, 0, 0);
    chk("tp_load_pc", fetch_pc, 8'h44);
    chk("tp_load_pend", exc_pending, 1'b0);

    tick(1, 8'hFE, 0, 0, 8'h00, 0, 6'h00, 0, 0);
    idle();
    chk("tp_wrap", fetch_pc, 8'h00);
    repeat (3) tick(0, 8'h00, 1, 1, 8'h40, 0, 6'h00, 0, 0);
    chk("tp_stall_hold", fetch_pc, 8'h00);
    tick(0, 8'h00, 1, 0, 8'h00, 0, 6'h00, 1, 0);
    chk("tp_exc_over_stall", fetch_pc, 8'hF0);

    // Exception and ack on one edge: exception wins (pending already set -> HALT)
    idle();
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 1, 1);
    chk("tp_exc_ack_halt", fsm_state, 2'd3);
    tick(1, 8'h10, 0, 0, 8'h00, 0, 6'h00, 0, 0);
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 1, 0);
    idle();
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 0, 1);
    chk("tp_ack_clears", exc_pending, 1'b0);

    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(15) == 0, 8'($urandom), $urandom_range(4) == 0,
           $urandom_range(2) == 0, 8'($urandom), $urandom_range(5) == 0,
           6'($urandom), $urandom_range(11) == 0, $urandom_range(5) == 0);
    end

    // Asynchronous reset in the middle of the EXC bubble
    tick(1, 8'h30, 0, 0, 8'h00, 0, 6'h00, 0, 0);
    tick(0, 8'h00, 0, 0, 8'h00, 0, 6'h00, 1, 0);
    chk("tp_pre_rst_state", fsm_state, 2'd2);
    #2 SYS_reset = 1'b1;
    #1;
    chk("tp_arst_pc", fetch_pc, 8'h00);
    chk("tp_arst_epc", epc, 8'h00);
    chk("tp_arst_pend", exc_pending, 1'b0);
    chk("tp_arst_state", fsm_state, 2'd0);
    model_reset();
    @(negedge SYS_clk); #2 SYS_reset = 1'b0;
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of IMEM and the decode/control path of the single-cycle CPU.
- Owns the program counter and next-PC selection: sequential, branch, jump, exception vector and external load.
- Also owns EPC capture and an exception/double-fault state machine.
- Drives fetch_pc into IMEM; the CPU datapath returns branch/jump/exception signals for the current instruction.

Parameters:
- PC_W, 8, program counter width in bits; byte address, word aligned.
- EXC_VECTOR, 8'hF0, PC loaded on an accepted exception.
- RESET_PC, 8'h00, PC value after reset.

Ports:
- SYS_clk  in  1  system clock; all state updates on the falling edge.
- SYS_reset  in  1  asynchronous, active-high reset.
- SYS_load  in  1  load fetch_pc from SYS_pc_val.
- SYS_pc_val  in  PC_W  external PC value; bits [1:0] are ignored.
- stall  in  1  hold the PC this cycle.
- branch_taken  in  1  ALU zero flag ANDed with the branch control bit.
- branch_offset  in  8  sign-extended immediate, low 8 bits, in words.
- jump  in  1  jump control bit.
- jump_target  in  6  byte target from the 4-to-6 expander.
- exception  in  1  exception output for the current instruction.
- exc_ack  in  1  clears exc_pending.
- fetch_pc  out  PC_W  address presented to IMEM.
- pc_plus4  out  PC_W  fetch_pc + 4, combinational.
- epc  out  PC_W  PC of the faulting instruction.
- exc_pending  out  1  sticky exception flag.
- fetch_valid  out  1  the instruction at fetch_pc may commit.
- fsm_state  out  2  0=BOOT, 1=RUN, 2=EXC, 3=HALT.

Behaviour:

Reset:
- Asynchronous reset sets fetch_pc=RESET_PC, epc=0, exc_pending=0, state=BOOT.
- During reset, fetch_valid=0 and fsm_state=0.

Arithmetic:
- All PC arithmetic is modulo 2^PC_W; no overflow flag.
- Bits [1:0] of fetch_pc are always 0.
- Branch target = pc_plus4 + (sign_ext(branch_offset) << 2).
- Jump target = {pc_plus4[7:6], jump_target[5:0]}; jump_target[1:0] are forced to 0.

Next-PC priority (highest first, evaluated at each falling edge):
1. SYS_load
   - fetch_pc <= {SYS_pc_val[7:2], 2'b00}.
   - exc_pending <= 0; state <= RUN from any state.
2. state HALT: fetch_pc holds; all other inputs are ignored.
3. exception, in RUN only:
   - If exc_pending=0: epc <= fetch_pc, fetch_pc <= EXC_VECTOR, exc_pending <= 1, state <= EXC.
   - If exc_pending=1 (double fault): epc unchanged, fetch_pc holds, state <= HALT.
4. stall=1: fetch_pc holds.
5. jump=1: fetch_pc <= jump target. jump has priority over branch_taken.
6. branch_taken=1: fetch_pc <= branch target.
7. Otherwise: fetch_pc <= pc_plus4.

State machine:
- BOOT: fetch_valid=0; always goes to RUN on the next edge; the PC does not advance.
- RUN: fetch_valid=1 unless stall=1.
- EXC: one-cycle bubble with fetch_valid=0; returns to RUN with the PC unchanged (already at EXC_VECTOR). Inputs in EXC other than SYS_load are ignored.
- HALT: fetch_valid=0; left only via SYS_load or reset.

exc_pending:
- exc_ack=1 clears exc_pending on the edge.
- If exception and exc_ack occur on the same edge, the exception wins: a new capture or HALT, per exc_pending before the edge.

Other rules:
- fetch_valid and fsm_state are combinational from the state and stall.
- exception has priority over stall.
- Reset asserted mid-operation immediately forces the reset values; no partial update.

Latency:
- The next-PC decision takes effect at the falling edge following the rising edge that completes the current instruction.
- fetch_pc is stable for a full rising-edge window.

Test Plan:
- Reset then 4 falling edges, no inputs -> BOOT for 1 cycle with fetch_valid=0; then fetch_pc = 0x00, 0x04, 0x08, 0x0C with fetch_valid=1.
- At fetch_pc=0x10: branch_taken=1, branch_offset=0xFE -> fetch_pc=0x0C. Then jump=1, jump_target=0x2A, branch_taken=1 -> fetch_pc=0x28 (jump wins; bits [1:0] forced 0).
- At fetch_pc=0x20, exception=1 -> epc=0x20, fetch_pc=0xF0, exc_pending=1, one EXC cycle with fetch_valid=0. A second exception in RUN -> HALT, fetch_pc frozen at 0xF0+n, epc still 0x20.
- In HALT: SYS_load=1, SYS_pc_val=0x47 -> fetch_pc=0x44, exc_pending=0, state RUN.
- At fetch_pc=0xFC with no control inputs -> wraps to 0x00. stall=1 for 3 cycles -> PC holds and fetch_valid=0. stall=1 plus exception -> exception taken.
- SYS_reset pulsed asynchronously between edges while in EXC -> fetch_pc=0x00, epc=0, exc_pending=0 immediately, without waiting for a clock edge.
